// File: rtl/counter_pkg.sv
// Shared types and constants for the button-driven counter front end.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SETTLE
    } state_t;

    // Array order doubles as priority: lowest index wins.
    localparam int BTN_IDX_CLR = 0;
    localparam int BTN_IDX_INC = 1;
    localparam int BTN_IDX_DEC = 2;
    localparam int NUM_BTNS    = 3;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;

endpackage

// File: rtl/button_conditioner.sv
// Two-flop synchronizer, debounce filter and one-cycle press pulse for a raw button.
module button_conditioner
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    output logic PRESS
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;

    // Any cycle where the synced level agrees with the stable level restarts the count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= BTN;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign PRESS = r_stable & ~r_stable_d;

endmodule

// File: rtl/button_counter_ctrl.sv
// Turns debounced clear/increment/decrement presses into a single-cycle LOAD
// with the next value for the downstream counter register.
module button_counter_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit SATURATE        = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             BTN_INC,
    input  logic             BTN_DEC,
    input  logic             BTN_CLR,
    input  logic [WIDTH-1:0] Q,
    output logic             LOAD,
    output logic [WIDTH-1:0] DIN,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [NUM_BTNS-1:0] w_btn_raw;
    logic [NUM_BTNS-1:0] w_press;

    assign w_btn_raw[BTN_IDX_CLR] = BTN_CLR;
    assign w_btn_raw[BTN_IDX_INC] = BTN_INC;
    assign w_btn_raw[BTN_IDX_DEC] = BTN_DEC;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_cond
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .CLK  (CLK),
            .RST_N(RST_N),
            .BTN  (w_btn_raw[g]),
            .PRESS(w_press[g])
        );
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_load;
    logic             w_load_nxt;
    logic [WIDTH-1:0] r_din;
    logic [WIDTH-1:0] w_din_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic             w_at_max;
    logic             w_at_min;

    assign w_inc    = Q + WIDTH'(1);
    assign w_dec    = Q - WIDTH'(1);
    assign w_at_max = (Q == ALL_ONES);
    assign w_at_min = (Q == '0);

    // Presses arriving outside IDLE are dropped; a saturated limit leaves the FSM in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_load_nxt  = 1'b0;
        w_din_nxt   = r_din;
        w_wrap_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_press[BTN_IDX_CLR]) begin
                    w_load_nxt  = 1'b1;
                    w_din_nxt   = '0;
                    w_state_nxt = APPLY;
                end else if (w_press[BTN_IDX_INC]) begin
                    if (!(SATURATE && w_at_max)) begin
                        w_load_nxt  = 1'b1;
                        w_din_nxt   = w_inc;
                        w_wrap_nxt  = w_at_max;
                        w_state_nxt = APPLY;
                    end
                end else if (w_press[BTN_IDX_DEC]) begin
                    if (!(SATURATE && w_at_min)) begin
                        w_load_nxt  = 1'b1;
                        w_din_nxt   = w_dec;
                        w_wrap_nxt  = w_at_min;
                        w_state_nxt = APPLY;
                    end
                end
            end
            APPLY:   w_state_nxt = SETTLE;
            SETTLE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_load  <= 1'b0;
            r_din   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_load  <= w_load_nxt;
            r_din   <= w_din_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign LOAD = r_load;
    assign DIN  = r_din;
    assign WRAP = r_wrap;

endmodule

// File: tb/tb_button_counter_ctrl.sv
// Bench for button_counter_ctrl: wrapping and saturating instances share the
// buttons, each closes the loop through its own register model.
module tb_button_counter_ctrl;

    localparam int W = 4;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic btn_inc = 1'b0;
    logic btn_dec = 1'b0;
    logic btn_clr = 1'b0;

    logic [W-1:0] q0 = '0;
    logic [W-1:0] q1 = '0;
    logic         load0, load1, wrap0, wrap1;
    logic [W-1:0] din0, din1;

    logic         force_en  = 1'b0;
    logic [W-1:0] force_val = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    button_counter_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .SATURATE(1'b0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .BTN_INC(btn_inc), .BTN_DEC(btn_dec), .BTN_CLR(btn_clr),
        .Q(q0), .LOAD(load0), .DIN(din0), .WRAP(wrap0)
    );

    button_counter_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .SATURATE(1'b1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .BTN_INC(btn_inc), .BTN_DEC(btn_dec), .BTN_CLR(btn_clr),
        .Q(q1), .LOAD(load1), .DIN(din1), .WRAP(wrap1)
    );

    // Downstream registers fed by each DUT; force only used to preset Q while idle.
    always @(posedge clk) begin
        if (load0) q0 <= din0; else if (force_en) q0 <= force_val;
        if (load1) q1 <= din1; else if (force_en) q1 <= force_val;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a button level is accepted once D consecutive synced samples
    // (raw delayed two edges) disagree with the accepted level; an accepted press is
    // acted on at the next edge unless the controller is still within two edges of a load.
    bit           smp  [3][D+2];
    bit           stb  [3];
    bit           pend [3];
    int           busy [2];
    logic         m_load [2];
    logic [W-1:0] m_din  [2];
    logic         m_wrap [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 3; b++) begin
                for (int i = 0; i < D + 2; i++) smp[b][i] = 1'b0;
                stb[b]  = 1'b0;
                pend[b] = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                busy[k] = 0; m_load[k] = 1'b0; m_din[k] = '0; m_wrap[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int qv, win, nv;
                bit wr;
                qv = (k == 0) ? int'(q0) : int'(q1);
                m_load[k] = 1'b0;
                m_wrap[k] = 1'b0;
                if (busy[k] > 0) begin
                    busy[k]--;
                end else begin
                    win = pend[0] ? 0 : pend[1] ? 1 : pend[2] ? 2 : -1;
                    if (win >= 0) begin
                        nv = 0; wr = 1'b0;
                        if (win == 1) begin nv = (qv + 1) % 16;  wr = (qv == 15); end
                        if (win == 2) begin nv = (qv + 15) % 16; wr = (qv == 0);  end
                        if (!(k == 1 && wr)) begin
                            m_load[k] = 1'b1; m_din[k] = W'(nv); m_wrap[k] = wr; busy[k] = 2;
                        end
                    end
                end
            end
            for (int b = 0; b < 3; b++) begin
                bit raw, all;
                raw = (b == 0) ? btn_clr : (b == 1) ? btn_inc : btn_dec;
                for (int i = D + 1; i > 0; i--) smp[b][i] = smp[b][i-1];
                smp[b][0] = raw;
                all = 1'b1;
                for (int i = 2; i <= D + 1; i++) if (smp[b][i] == stb[b]) all = 1'b0;
                pend[b] = 1'b0;
                if (all) begin
                    stb[b]  = !stb[b];
                    pend[b] = stb[b];
                end
            end
        end
    end

    always @(negedge clk) begin
        check("load0", load0, m_load[0]);
        check("din0",  din0,  m_din[0]);
        check("wrap0", wrap0, m_wrap[0]);
        check("load1", load1, m_load[1]);
        check("din1",  din1,  m_din[1]);
        check("wrap1", wrap1, m_wrap[1]);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_q(input int v);
        force_val = W'(v);
        force_en  = 1'b1;
        tick(1);
        force_en  = 1'b0;
    endtask

    // mask = {clr, inc, dec}; qv < 0 keeps the current Q.
    task automatic press_check(input string nm, input logic [2:0] mask, input int qv,
                               input int exp_din, input int exp_wrap, input int exp_load1,
                               input bit bounce, input int hold, input int rel);
        int nloads;
        if (qv >= 0) set_q(qv);
        nloads = 0;
        if (bounce) begin
            for (int i = 0; i < 4; i++) begin
                {btn_clr, btn_inc, btn_dec} = (i % 2 == 0) ? mask : 3'b000;
                tick(1);
                nloads += int'(load0);
            end
        end
        {btn_clr, btn_inc, btn_dec} = mask;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            nloads += int'(load0);
        end
        check({nm, "_early"}, nloads, 0);
        tick(1);
        check({nm, "_load"},  load0, 1);
        check({nm, "_din"},   din0,  exp_din);
        check({nm, "_wrap"},  wrap0, exp_wrap);
        check({nm, "_load1"}, load1, exp_load1);
        tick(1);
        check({nm, "_q"},     q0,    exp_din);
        check({nm, "_drop"},  load0, 0);
        nloads = 0;
        for (int i = 0; i < hold; i++) begin
            tick(1);
            nloads += int'(load0);
        end
        check({nm, "_single"}, nloads, 0);
        {btn_clr, btn_inc, btn_dec} = 3'b000;
        tick(rel);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_load0", load0, 0);
        check("rst_din0",  din0,  0);
        check("rst_wrap0", wrap0, 0);
        check("rst_load1", load1, 0);
        tick(3);
        rst_n = 1'b1;
        tick(5);

        press_check("inc7",    3'b010, 7,  8,  0, 1, 1'b0, 30, 20);
        press_check("bounce",  3'b010, 2,  3,  0, 1, 1'b1, 20, 20);
        press_check("wrapinc", 3'b010, 15, 0,  1, 0, 1'b0, 20, 20);
        check("sat_q1_hold", q1, 15);
        press_check("wrapdec", 3'b001, 0,  15, 1, 0, 1'b0, 20, 20);
        press_check("clrinc",  3'b110, 9,  0,  0, 1, 1'b0, 30, 20);
        press_check("clr0",    3'b100, 0,  0,  0, 1, 1'b0, 10, 20);
        press_check("hold1",   3'b001, 5,  4,  0, 1, 1'b0, 32, 10);
        press_check("hold2",   3'b001, -1, 3,  0, 1, 1'b0, 10, 20);

        // Reset in the middle of the load pulse, button kept held across it.
        set_q(3);
        btn_inc = 1'b1;
        tick(7);
        check("abort_load", load0, 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_load0", load0, 0);
        check("abort_din0",  din0,  0);
        check("abort_wrap0", wrap0, 0);
        tick(3);
        rst_n = 1'b1;
        tick(6);
        check("rehold_early", load0, 0);
        tick(1);
        check("rehold_load", load0, 1);
        check("rehold_din",  din0,  4);
        btn_inc = 1'b0;
        tick(20);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) btn_clr = ~btn_clr;
            if ($urandom_range(0, 4) == 0) btn_inc = ~btn_inc;
            if ($urandom_range(0, 4) == 0) btn_dec = ~btn_dec;
            tick(1);
        end
        {btn_clr, btn_inc, btn_dec} = 3'b000;
        tick(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
